// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - SAP six-state ring counter and opcode decode driving all datapath controls
module sap_control_sequencer (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       hlt
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_t;

    tstate_t state, state_next;
    logic    hlt_q, hlt_next;
    logic    c_cp, c_ep, c_lm, c_ce, c_li, c_ei, c_la, c_ea, c_su, c_eu, c_lb, c_lo;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= T1;
            hlt_q <= 1'b0;
        end else begin
            state <= state_next;
            hlt_q <= hlt_next;
        end
    end

    always_comb begin
        state_next = state;
        hlt_next   = hlt_q;
        {c_cp, c_ep, c_lm, c_ce, c_li, c_ei, c_la, c_ea, c_su, c_eu, c_lb, c_lo} = '0;
        // Once halted the ring stays parked at T4 with every control low
        if (!hlt_q) begin
            unique case (state)
                T1: begin c_ep = 1'b1; c_lm = 1'b1; state_next = T2; end
                T2: begin c_cp = 1'b1; state_next = T3; end
                T3: begin c_ce = 1'b1; c_li = 1'b1; state_next = T4; end
                T4: begin
                    state_next = T5;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin c_ei = 1'b1; c_lm = 1'b1; end
                        OP_OUT: begin c_ea = 1'b1; c_lo = 1'b1; end
                        OP_HLT: begin hlt_next = 1'b1; state_next = T4; end
                        default: ;
                    endcase
                end
                T5: begin
                    state_next = T6;
                    case (opcode)
                        OP_LDA: begin c_ce = 1'b1; c_la = 1'b1; end
                        OP_ADD, OP_SUB: begin c_ce = 1'b1; c_lb = 1'b1; end
                        default: ;
                    endcase
                end
                T6: begin
                    state_next = T1;
                    case (opcode)
                        OP_ADD: begin c_eu = 1'b1; c_la = 1'b1; end
                        OP_SUB: begin c_eu = 1'b1; c_su = 1'b1; c_la = 1'b1; end
                        default: ;
                    endcase
                end
                default: state_next = T1;
            endcase
        end
    end

    // Reset gates the control word combinationally so nothing fires while clr_n is low
    assign {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = clr_n ?
        {c_cp, c_ep, c_lm, c_ce, c_li, c_ei, c_la, c_ea, c_su, c_eu, c_lb, c_lo} : 12'b0;
    assign t_state = state;
    assign hlt     = hlt_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb/tb_sap_control_sequencer.sv - scoreboard bench for sap_control_sequencer with a small SAP datapath model
module tb_sap_control_sequencer;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_NOP = 4'b0101;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int C_CP = 11, C_EP = 10, C_LM = 9, C_CE = 8, C_LI = 7, C_EI = 6;
    localparam int C_LA = 5, C_EA = 4, C_SU = 3, C_EU = 2, C_LB = 1, C_LO = 0;

    localparam logic [18:0] RST_W = {1'b0, 6'b000001, 12'b0};
    localparam logic [18:0] HLT_W = {1'b1, 6'b001000, 12'b0};

    logic       clk = 1'b0;
    logic       clr_n;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;

    logic [7:0] bus, mem_val;
    logic [7:0] acc = 8'h00;
    logic [7:0] breg = 8'h00;
    logic [7:0] pc = 8'h00;

    logic [18:0] exp_q[$];
    logic [7:0]  bus_q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sap_control_sequencer dut (
        .clk(clk), .clr_n(clr_n), .opcode(opcode), .t_state(t_state),
        .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la),
        .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo), .hlt(hlt)
    );

    // Minimal datapath: bus mux plus ACC/B/PC registers driven by the DUT's controls
    always_comb begin
        bus = 8'h00;
        if (ep)      bus = pc;
        else if (ce) bus = mem_val;
        else if (ei) bus = 8'h0F;
        else if (ea) bus = acc;
        else if (eu) bus = su ? acc - breg : acc + breg;
    end

    always @(posedge clk) begin
        if (la) acc <= bus;
        if (lb) breg <= bus;
        if (cp) pc <= pc + 8'h01;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] exp_word(input logic [3:0] op, input int step);
        logic [11:0] c;
        logic [5:0]  t;
        c = '0;
        t = 6'(1 << step);
        case (step)
            0: begin c[C_EP] = 1'b1; c[C_LM] = 1'b1; end
            1: c[C_CP] = 1'b1;
            2: begin c[C_CE] = 1'b1; c[C_LI] = 1'b1; end
            3: begin
                if (op == OP_LDA || op == OP_ADD || op == OP_SUB) begin c[C_EI] = 1'b1; c[C_LM] = 1'b1; end
                else if (op == OP_OUT) begin c[C_EA] = 1'b1; c[C_LO] = 1'b1; end
            end
            4: begin
                if (op == OP_LDA) begin c[C_CE] = 1'b1; c[C_LA] = 1'b1; end
                else if (op == OP_ADD || op == OP_SUB) begin c[C_CE] = 1'b1; c[C_LB] = 1'b1; end
            end
            5: begin
                if (op == OP_ADD) begin c[C_EU] = 1'b1; c[C_LA] = 1'b1; end
                else if (op == OP_SUB) begin c[C_EU] = 1'b1; c[C_SU] = 1'b1; c[C_LA] = 1'b1; end
            end
            default: ;
        endcase
        return {1'b0, t, c};
    endfunction

    // Entered at posedge+1; drives one cycle, checks mid-cycle, returns at next posedge+1
    task automatic cycle(input string tag, input logic [3:0] op, input logic [18:0] ew,
                         input bit bchk, input logic [7:0] eb);
        logic [18:0] w;
        logic [7:0]  b;
        opcode = op;
        exp_q.push_back(ew);
        if (bchk) bus_q.push_back(eb);
        #2;
        if (exp_q.size() == 0) check({tag, "_qempty"}, 1, 0);
        else begin
            w = exp_q.pop_front();
            check(tag, {13'b0, hlt, t_state, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo}, {13'b0, w});
        end
        check({tag, "_drv1hot"}, 32'($countones({ep, ce, ei, ea, eu}) <= 1), 1);
        check({tag, "_su_eu"}, {31'b0, su & ~eu}, 0);
        check({tag, "_ring1hot"}, {31'b0, $onehot(t_state)}, 1);
        if (bchk) begin
            b = bus_q.pop_front();
            check({tag, "_bus"}, {24'b0, bus}, {24'b0, b});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        cycle("rst_a", 4'($urandom_range(0, 15)), RST_W, 1'b0, 8'h00);
        cycle("rst_b", 4'($urandom_range(0, 15)), RST_W, 1'b0, 8'h00);
        clr_n = 1'b1;
    endtask

    // Opcode is garbage during fetch; abort_at < 6 pulls reset in that step
    task automatic run_instr(input string tag, input logic [3:0] op, input logic [7:0] memv,
                             input bit bchk, input logic [7:0] eb, input int abort_at);
        mem_val = memv;
        for (int s = 0; s < 6; s++) begin
            if (s == abort_at) begin
                do_reset();
                return;
            end
            cycle($sformatf("%s_s%0d", tag, s + 1), (s < 3) ? 4'($urandom_range(0, 15)) : op,
                  exp_word(op, s),
                  bchk && ((op == OP_OUT && s == 3) || (op != OP_OUT && s == 5)), eb);
        end
    endtask

    initial begin
        clr_n   = 1'b0;
        opcode  = 4'h0;
        mem_val = 8'h00;
        @(posedge clk);
        #1;
        do_reset();
        run_instr("lda33", OP_LDA, 8'h33, 1'b0, 8'h00, 6);
        run_instr("add",   OP_ADD, 8'hAA, 1'b1, 8'hDD, 6);
        run_instr("lda69", OP_LDA, 8'h69, 1'b0, 8'h00, 6);
        run_instr("sub",   OP_SUB, 8'hBB, 1'b1, 8'hAE, 6);
        run_instr("out",   OP_OUT, 8'h00, 1'b1, 8'hAE, 6);
        run_instr("nop",   OP_NOP, 8'h5A, 1'b0, 8'h00, 6);
        run_instr("addab", OP_ADD, 8'h11, 1'b0, 8'h00, 4);
        run_instr("lda01", OP_LDA, 8'h01, 1'b0, 8'h00, 6);
        for (int s = 0; s < 4; s++)
            cycle($sformatf("hlt_s%0d", s + 1), (s < 3) ? 4'($urandom_range(0, 15)) : OP_HLT,
                  exp_word(OP_HLT, s), 1'b0, 8'h00);
        for (int k = 0; k < 20; k++)
            cycle($sformatf("halted%0d", k), 4'($urandom_range(0, 15)), HLT_W, 1'b0, 8'h00);
        do_reset();
        run_instr("post", OP_SUB, 8'h02, 1'b0, 8'h00, 6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
